instruction_fetch_unit: RTL and testbench

- Requester side of the program ROM interface: drives the 16-bit ROM address and consumes the 28-bit instruction word the ROM returns combinationally.
- Holds the program counter and one instruction register (fetch/decode stage) in front of the execute unit.
- Resolves JMP locally; accepts stall and taken-branch redirects from execute.
- Presents decoded fields plus a valid flag to execute.

---
 rtl/instruction_fetch_unit.sv | 101 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch/decode front end: owns the program counter and a single instruction
// register, resolves JMP locally and honours stall/branch requests from execute.
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_ADDRESS = 16'd0,
    parameter int          INSTR_WIDTH   = 28
) (
    input  logic                   Clock,
    input  logic                   Reset,
    output logic [15:0]            oAddress,
    input  logic [INSTR_WIDTH-1:0] iInstruction,
    input  logic                   iStall,
    input  logic                   iBranchTaken,
    input  logic [15:0]            iBranchAddress,
    output logic                   oValid,
    output logic [3:0]             oOperation,
    output logic [7:0]             oDestination,
    output logic [7:0]             oSourceA,
    output logic [7:0]             oSourceB,
    output logic [15:0]            oImmediate
);

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [INSTR_WIDTH-1:0] NOP_WORD = {OP_NOP, {(INSTR_WIDTH-4){1'b0}}};

    typedef enum logic {
        BOOT,
        RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [15:0]            pc_q, pc_d;
    logic [INSTR_WIDTH-1:0] ir_q, ir_d;
    logic                   ir_valid_q, ir_valid_d;
    logic                   fetch_is_jmp;

    assign fetch_is_jmp = (iInstruction[27:24] == OP_JMP);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= BOOT;
            pc_q       <= RESET_ADDRESS;
            ir_q       <= NOP_WORD;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    // BOOT ignores stall and redirect: nothing valid is on the outputs yet
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = ir_valid_q;
        case (state_q)
            BOOT: begin
                state_d = RUN;
                if (fetch_is_jmp) begin
                    pc_d       = {8'd0, iInstruction[23:16]};
                    ir_d       = NOP_WORD;
                    ir_valid_d = 1'b0;
                end else begin
                    pc_d       = pc_q + 16'd1;
                    ir_d       = iInstruction;
                    ir_valid_d = 1'b1;
                end
            end
            RUN: begin
                if (iBranchTaken) begin
                    pc_d       = iBranchAddress;
                    ir_d       = NOP_WORD;
                    ir_valid_d = 1'b0;
                end else if (iStall) begin
                    pc_d       = pc_q;
                end else if (fetch_is_jmp) begin
                    pc_d       = {8'd0, iInstruction[23:16]};
                    ir_d       = NOP_WORD;
                    ir_valid_d = 1'b0;
                end else begin
                    pc_d       = pc_q + 16'd1;
                    ir_d       = iInstruction;
                    ir_valid_d = 1'b1;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    assign oAddress     = pc_q;
    assign oValid       = ir_valid_q;
    assign oOperation   = ir_q[27:24];
    assign oDestination = ir_q[23:16];
    assign oSourceA     = ir_q[15:8];
    assign oSourceB     = ir_q[7:0];
    assign oImmediate   = ir_q[15:0];

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a small program ROM model drives
// the fetch port and each scenario task checks the address and decoded fields.
module tb_instruction_fetch_unit;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_STO = 4'h8;
    localparam logic [3:0] OP_JMP = 4'hC;

    logic        Clock;
    logic        Reset;
    logic [15:0] oAddress;
    logic [27:0] iInstruction;
    logic        iStall;
    logic        iBranchTaken;
    logic [15:0] iBranchAddress;
    logic        oValid;
    logic [3:0]  oOperation;
    logic [7:0]  oDestination;
    logic [7:0]  oSourceA;
    logic [7:0]  oSourceB;
    logic [15:0] oImmediate;

    int assertCount = 0;
    int failCount   = 0;

    logic [27:0] prog [0:7];

    instruction_fetch_unit #(
        .RESET_ADDRESS(16'd0),
        .INSTR_WIDTH(28)
    ) dut (
        .Clock(Clock),
        .Reset(Reset),
        .oAddress(oAddress),
        .iInstruction(iInstruction),
        .iStall(iStall),
        .iBranchTaken(iBranchTaken),
        .iBranchAddress(iBranchAddress),
        .oValid(oValid),
        .oOperation(oOperation),
        .oDestination(oDestination),
        .oSourceA(oSourceA),
        .oSourceB(oSourceB),
        .oImmediate(oImmediate)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Combinational ROM: test program in 0..7, a recognisable ADD word elsewhere
    always_comb begin
        if (oAddress < 16'd8)
            iInstruction = prog[oAddress[2:0]];
        else
            iInstruction = {OP_ADD, oAddress[7:0], 8'h5A, 8'hA5};
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        iStall = 1'b0;
        iBranchTaken = 1'b0;
        iBranchAddress = 16'h0000;
        repeat (3) step();
        assertCount++;
        if (oAddress !== 16'h0000) begin
            failCount++;
            $display("[TB] FAIL reset_address: got %h expected 0000", oAddress);
        end
        assertCount++;
        if (oValid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_valid: got %b expected 0", oValid);
        end
        assertCount++;
        if ({oOperation, oDestination, oImmediate} !== 28'h0) begin
            failCount++;
            $display("[TB] FAIL reset_fields: got %h expected 0000000", {oOperation, oDestination, oImmediate});
        end
        Reset = 1'b1;
        step();
        assertCount++;
        if (oAddress !== 16'h0001 || oValid !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL boot_addr_valid: got %h/%b expected 0001/1", oAddress, oValid);
        end
        assertCount++;
        if (oOperation !== OP_STO || oDestination !== 8'h00) begin
            failCount++;
            $display("[TB] FAIL boot_fields: got op %h dst %h expected op %h dst 00", oOperation, oDestination, OP_STO);
        end
    endtask

    task automatic test_sequential();
        for (int a = 1; a <= 7; a++) begin
            assertCount++;
            if (oAddress !== 16'(a)) begin
                failCount++;
                $display("[TB] FAIL seq_address[%0d]: got %h expected %h", a, oAddress, 16'(a));
            end
            assertCount++;
            if (oValid !== 1'b1 || {oOperation, oDestination, oImmediate} !== prog[a-1]) begin
                failCount++;
                $display("[TB] FAIL seq_ir[%0d]: got %b/%h expected 1/%h", a, oValid,
                         {oOperation, oDestination, oImmediate}, prog[a-1]);
            end
            if (a < 7) step();
        end
    endtask

    task automatic test_jmp();
        step();
        assertCount++;
        if (oAddress !== 16'h0003 || oValid !== 1'b0 || oOperation !== OP_NOP) begin
            failCount++;
            $display("[TB] FAIL jmp_bubble: got %h/%b/%h expected 0003/0/%h", oAddress, oValid, oOperation, OP_NOP);
        end
        step();
        assertCount++;
        if (oAddress !== 16'h0004 || oValid !== 1'b1 || oOperation !== OP_NOP) begin
            failCount++;
            $display("[TB] FAIL jmp_after: got %h/%b/%h expected 0004/1/%h", oAddress, oValid, oOperation, OP_NOP);
        end
        step();
        assertCount++;
        if (oAddress !== 16'h0005 || oOperation !== OP_ADD || oDestination !== 8'h04) begin
            failCount++;
            $display("[TB] FAIL loop_repeat: got %h/%h/%h expected 0005/%h/04", oAddress, oOperation, oDestination, OP_ADD);
        end
    endtask

    task automatic test_stall();
        iStall = 1'b1;
        for (int c = 0; c < 2; c++) begin
            step();
            assertCount++;
            if (oAddress !== 16'h0005 || oOperation !== OP_ADD || oImmediate !== 16'h4142) begin
                failCount++;
                $display("[TB] FAIL stall_hold[%0d]: got %h/%h/%h expected 0005/%h/4142", c, oAddress, oOperation, oImmediate, OP_ADD);
            end
        end
        iStall = 1'b0;
        step();
        assertCount++;
        if (oAddress !== 16'h0006 || oDestination !== 8'h05 || oValid !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL stall_release: got %h/%h/%b expected 0006/05/1", oAddress, oDestination, oValid);
        end
    endtask

    task automatic test_branch_beats_stall();
        iBranchTaken = 1'b1;
        iBranchAddress = 16'h0002;
        iStall = 1'b1;
        step();
        iBranchTaken = 1'b0;
        iStall = 1'b0;
        assertCount++;
        if (oAddress !== 16'h0002 || oValid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL branch_over_stall: got %h/%b expected 0002/0", oAddress, oValid);
        end
        step();
        assertCount++;
        if (oAddress !== 16'h0003 || oValid !== 1'b1 || oOperation !== OP_STO || oDestination !== 8'h02) begin
            failCount++;
            $display("[TB] FAIL branch_target: got %h/%b/%h/%h expected 0003/1/%h/02", oAddress, oValid, oOperation, oDestination, OP_STO);
        end
    endtask

    task automatic test_wrap_and_async_reset();
        iBranchTaken = 1'b1;
        iBranchAddress = 16'hFFFF;
        step();
        iBranchTaken = 1'b0;
        assertCount++;
        if (oAddress !== 16'hFFFF || oValid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL wrap_branch: got %h/%b expected FFFF/0", oAddress, oValid);
        end
        step();
        assertCount++;
        if (oAddress !== 16'h0000 || oValid !== 1'b1 || oOperation !== OP_ADD || oDestination !== 8'hFF) begin
            failCount++;
            $display("[TB] FAIL wrap_increment: got %h/%b/%h/%h expected 0000/1/%h/FF", oAddress, oValid, oOperation, oDestination, OP_ADD);
        end
        step();
        #2;
        Reset = 1'b0;
        #1;
        assertCount++;
        if (oAddress !== 16'h0000 || oValid !== 1'b0 || oOperation !== OP_NOP) begin
            failCount++;
            $display("[TB] FAIL async_reset: got %h/%b/%h expected 0000/0/%h", oAddress, oValid, oOperation, OP_NOP);
        end
        @(negedge Clock);
        Reset = 1'b1;
        step();
        assertCount++;
        if (oAddress !== 16'h0001 || oValid !== 1'b1 || oOperation !== OP_STO) begin
            failCount++;
            $display("[TB] FAIL reboot: got %h/%b/%h expected 0001/1/%h", oAddress, oValid, oOperation, OP_STO);
        end
    endtask

    initial begin
        prog[0] = {OP_STO, 8'h00, 8'h10, 8'h20};
        prog[1] = {OP_STO, 8'h01, 8'h11, 8'h21};
        prog[2] = {OP_STO, 8'h02, 8'h12, 8'h22};
        prog[3] = {OP_NOP, 8'h00, 8'h00, 8'h00};
        prog[4] = {OP_ADD, 8'h04, 8'h41, 8'h42};
        prog[5] = {OP_ADD, 8'h05, 8'h51, 8'h52};
        prog[6] = {OP_ADD, 8'h06, 8'h61, 8'h62};
        prog[7] = {OP_JMP, 8'h03, 8'h00, 8'h00};

        test_reset();
        test_sequential();
        test_jmp();
        test_stall();
        test_branch_beats_stall();
        test_wrap_and_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
